parity_stream_gen: RTL and testbench

Streaming, parametrised parity generator for the FPGA test datapaths. Accepts a valid/ready word stream framed by a `last` flag. Emits each word one cycle later with its per-word parity bit. On the final word of each packet it also emits the accumulated packet parity and the packet length. Even or odd parity is selectable per packet, and an optional checker compares the packet parity against a supplied reference.

---
 rtl/parity_stream_gen.sv | 160 ++++++++++++++++
 tb/tb_parity_stream_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parity_stream_gen: per-word and per-packet parity over a valid/ready stream |
// | Optional checker: define PARITY_CHECK_EN.  Rev 1.0                          |
// +----------------------------------------------------------------------------+
module parity_stream_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             odd_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             out_par,
  output logic             pkt_par,
  output logic [LEN_W-1:0] pkt_len
`ifdef PARITY_CHECK_EN
  ,
  input  logic             chk_par,
  output logic             pkt_err,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_ACC  = 1'b1;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  logic             state_q, state_d;
  logic             mode_q, mode_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_par_q, out_par_d;
  logic             pkt_par_q, pkt_par_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;

  logic             accept;
  logic             first;
  logic             word_mode;
  logic             word_x;
  logic             acc_incl;
  logic [LEN_W-1:0] cnt_incl;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == ST_IDLE);

  // A packet's first word uses the odd_sel being latched, later words the stored mode
  assign word_mode = first ? odd_sel : mode_q;
  assign word_x    = ^in_data;
  assign acc_incl  = first ? word_x : (acc_q ^ word_x);
  assign cnt_incl  = first ? CNT_ONE : ((cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_par_q   <= 1'b0;
      pkt_par_q   <= 1'b0;
      pkt_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_par_q   <= out_par_d;
      pkt_par_q   <= pkt_par_d;
      pkt_len_q   <= pkt_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? ST_IDLE : ST_ACC;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_par_d   = out_par_q;
    pkt_par_d   = pkt_par_q;
    pkt_len_d   = pkt_len_q;
    if (accept) begin
      mode_d      = word_mode;
      acc_d       = acc_incl;
      cnt_d       = cnt_incl;
      out_data_d  = in_data;
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      out_par_d   = word_x ^ word_mode;
      pkt_par_d   = in_last ? (acc_incl ^ word_mode) : 1'b0;
      pkt_len_d   = in_last ? cnt_incl : '0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_par   = out_par_q;
  assign pkt_par   = pkt_par_q;
  assign pkt_len   = pkt_len_q;

`ifdef PARITY_CHECK_EN
  logic       pkt_err_q, pkt_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      pkt_err_q <= pkt_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    pkt_err_d = pkt_err_q;
    err_cnt_d = err_cnt_q;
    if (out_valid_q && out_ready && out_last_q && pkt_err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    if (accept) begin
      pkt_err_d = in_last ? ((acc_incl ^ word_mode) != chk_par) : 1'b0;
    end
  end

  assign pkt_err = pkt_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_stream_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parity_stream_gen: directed, table-driven bench for parity_stream_gen    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_parity_stream_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, odd_sel, out_ready;
  wire        in_ready, out_valid, out_last, out_par, pkt_par;
  wire  [7:0] out_data, pkt_len;
  wire        d2_in_ready, d2_out_valid, d2_out_last, d2_out_par, d2_pkt_par;
  wire  [7:0] d2_out_data;
  wire  [1:0] d2_pkt_len;
`ifdef PARITY_CHECK_EN
  logic       chk_par;
  wire        pkt_err, d2_pkt_err;
  wire  [7:0] err_cnt, d2_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parity_stream_gen #(.WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .odd_sel(odd_sel), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .out_par(out_par), .pkt_par(pkt_par),
    .pkt_len(pkt_len)
`ifdef PARITY_CHECK_EN
    , .chk_par(chk_par), .pkt_err(pkt_err), .err_cnt(err_cnt)
`endif
  );

  parity_stream_gen #(.WIDTH(8), .LEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(d2_in_ready), .odd_sel(odd_sel), .out_data(d2_out_data), .out_valid(d2_out_valid),
    .out_last(d2_out_last), .out_ready(out_ready), .out_par(d2_out_par), .pkt_par(d2_pkt_par),
    .pkt_len(d2_pkt_len)
`ifdef PARITY_CHECK_EN
    , .chk_par(chk_par), .pkt_err(d2_pkt_err), .err_cnt(d2_err_cnt)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       odd;
    logic       par;
    logic       ppar;
    logic [7:0] len;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one word, clock it in, then sample #1 after the edge
  task automatic step(input logic [7:0] d, input logic v, input logic l, input logic o);
    in_data  = d;
    in_valid = v;
    in_last  = l;
    odd_sel  = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[4] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    vecs[7] = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; odd_sel = 1'b0;
    out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
    chk_par = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_data", out_data, 0);
    chk("reset pkt_len", pkt_len, 0);
    chk("reset pkt_par", pkt_par, 0);
    rst = 1'b0;

    // Back-to-back continuous flow through the vector table
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].data, 1'b1, vecs[i].last, vecs[i].odd);
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d out_data", i), out_data, vecs[i].data);
      chk($sformatf("v%0d out_last", i), out_last, vecs[i].last);
      chk($sformatf("v%0d out_par", i), out_par, vecs[i].par);
      chk($sformatf("v%0d pkt_par", i), pkt_par, vecs[i].ppar);
      chk($sformatf("v%0d pkt_len", i), pkt_len, vecs[i].len);
    end
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("drain out_valid", out_valid, 0);

    // Backpressure mid-packet
    step(8'h11, 1'b1, 1'b0, 1'b0);
    step(8'h22, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_data = 8'h33; in_last = 1'b1; #1;
    chk("stall in_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d in_ready", i), in_ready, 0);
      chk($sformatf("stall%0d out_valid", i), out_valid, 1);
      chk($sformatf("stall%0d out_data", i), out_data, 8'h22);
      chk($sformatf("stall%0d out_last", i), out_last, 0);
    end
    out_ready = 1'b1;
    step(8'h33, 1'b1, 1'b1, 1'b0);
    chk("bp out_data", out_data, 8'h33);
    chk("bp out_last", out_last, 1);
    chk("bp pkt_par", pkt_par, 0);
    chk("bp pkt_len", pkt_len, 3);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    // Length saturation on the narrow counter
    for (int i = 0; i < 5; i++) step(8'h01, 1'b1, (i == 4), 1'b0);
    chk("sat d2 pkt_len", d2_pkt_len, 3);
    chk("sat d2 pkt_par", d2_pkt_par, 1);
    chk("sat pkt_len", pkt_len, 5);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    // Reset mid-packet: first two of four words, then async reset
    step(8'h0F, 1'b1, 1'b0, 1'b1);
    step(8'h01, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1; #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    step(8'h80, 1'b1, 1'b1, 1'b0);
    chk("post-rst out_valid", out_valid, 1);
    chk("post-rst out_par", out_par, 1);
    chk("post-rst pkt_par", pkt_par, 1);
    chk("post-rst pkt_len", pkt_len, 1);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("post-rst drain", out_valid, 0);

`ifdef PARITY_CHECK_EN
    rst = 1'b1; #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("chk reset err_cnt", err_cnt, 0);
    chk_par = 1'b1;
    step(8'h03, 1'b1, 1'b1, 1'b0);
    chk("chk1 pkt_err", pkt_err, 1);
    chk("chk1 err_cnt before", err_cnt, 0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("chk1 err_cnt after", err_cnt, 1);
    chk_par = 1'b0;
    step(8'h03, 1'b1, 1'b1, 1'b0);
    chk("chk2 pkt_err", pkt_err, 0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("chk2 err_cnt", err_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
